// File: rtl/fp_unpacker.sv
// Purpose : split an IEEE-style packed float into sign, unbiased exponent,
//           significand with explicit hidden bit, and class flags.
// Latency : 2 cycles (S1 field split + classify, S2 normalise); 1 op/cycle.
// Backpressure: valid/ready on both sides; each stage refills when empty or
//           draining; in_ready is combinational from out_ready; outputs hold
//           stable while out_valid && !out_ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   op[W-1:0]             packed operand {sign, exponent, fraction}
//   in_valid / in_ready   input handshake
//   out_valid / out_ready output handshake
//   res_s                 sign (passed through for every class)
//   res_e[XW-1:0]         signed two's-complement unbiased exponent
//   res_m[MAN_W:0]        significand including the explicit hidden bit
//   nan qnan inf denorm zero  class flags
//
// Build option: define FP_UNPACKER_DENORM_NORM_EN to normalise denormals
// (leading-zero count + shift in S2). Without it denormals are flushed to a
// signed zero and flagged as both denorm and zero.

module fp_unpacker #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [EXP_W+MAN_W:0]   op,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   res_s,
  output logic [EXP_W+1:0]       res_e,
  output logic [MAN_W:0]         res_m,
  output logic                   nan,
  output logic                   qnan,
  output logic                   inf,
  output logic                   denorm,
  output logic                   zero
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int BIAS = (2 ** (EXP_W - 1)) - 1;
  localparam int XW   = EXP_W + 2;

  // S1 payload: raw fields plus the final class flags.
  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    logic             nan;
    logic             qnan;
    logic             inf;
    logic             denorm;
    logic             zero;
  } s1_dat_t;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic    s1_vld;
  logic    s2_vld;
  logic    s2_rdy;
  s1_dat_t s1_q;
  s1_dat_t s1_nxt;

  // S2 can take new data when empty or when its current result is leaving.
  assign s2_rdy    = !s2_vld || out_ready;
  // S1 advances exactly when it holds data and S2 can take it.
  assign in_ready  = !s1_vld || s2_rdy;
  assign out_valid = s2_vld;

  // ---------------------------------------------------------------------------
  // S1 decode: field split and classification
  // ---------------------------------------------------------------------------
  logic [EXP_W-1:0] op_e;
  logic [MAN_W-1:0] op_f;
  logic             e_ones;
  logic             e_zero;
  logic             f_nz;

  always_comb begin
    op_e   = op[W-2:MAN_W];
    op_f   = op[MAN_W-1:0];
    e_ones = &op_e;
    e_zero = ~|op_e;
    f_nz   = |op_f;

    s1_nxt        = '0;
    s1_nxt.s      = op[W-1];
    s1_nxt.e      = op_e;
    s1_nxt.f      = op_f;
    s1_nxt.nan    = e_ones & f_nz;
    s1_nxt.qnan   = e_ones & f_nz & op_f[MAN_W-1];
    s1_nxt.inf    = e_ones & ~f_nz;
    s1_nxt.denorm = e_zero & f_nz;
`ifdef FP_UNPACKER_DENORM_NORM_EN
    s1_nxt.zero   = e_zero & ~f_nz;
`else
    // Flushed denormals read as zero as well as denorm.
    s1_nxt.zero   = e_zero;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
    end else begin
      if (in_ready) begin
        s1_vld <= in_valid;
      end
      if (in_valid && in_ready) begin
        s1_q <= s1_nxt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2 normalise
  // ---------------------------------------------------------------------------
  logic [XW-1:0]    nx_e;
  logic [MAN_W:0]   nx_m;

`ifdef FP_UNPACKER_DENORM_NORM_EN
  localparam int LZW = $clog2(MAN_W + 1);
  logic [LZW-1:0] lz;
  logic [LZW-1:0] lz_sh;

  // Leading zeros of the fraction: the highest set bit wins because the
  // loop walks upward and later assignments override earlier ones.
  always_comb begin
    lz = '0;
    for (int i = 0; i < MAN_W; i++) begin
      if (s1_q.f[i]) begin
        lz = LZW'(MAN_W - 1 - i);
      end
    end
    // lz+1 never exceeds MAN_W, which always fits in LZW bits.
    lz_sh = lz + LZW'(1);
  end
`endif

  always_comb begin
    nx_e = '0;
    nx_m = '0;
    if (s1_q.nan || s1_q.inf) begin
      nx_e = XW'(BIAS + 1);
      nx_m = {1'b0, s1_q.f};
    end else if (s1_q.zero) begin
      // Zeros (and flushed denormals) keep the all-zero result.
      nx_e = '0;
      nx_m = '0;
`ifdef FP_UNPACKER_DENORM_NORM_EN
    end else if (s1_q.denorm) begin
      // Shift the top set bit into the hidden-bit position; the value is
      // f * 2^(1-BIAS-MAN_W), so the exponent becomes -BIAS - lz.
      nx_m = {1'b0, s1_q.f} << lz_sh;
      nx_e = (-XW'(BIAS)) - XW'(lz);
`endif
    end else begin
      nx_e = {2'b00, s1_q.e} - XW'(BIAS);
      nx_m = {1'b1, s1_q.f};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      res_s  <= 1'b0;
      res_e  <= '0;
      res_m  <= '0;
      nan    <= 1'b0;
      qnan   <= 1'b0;
      inf    <= 1'b0;
      denorm <= 1'b0;
      zero   <= 1'b0;
    end else begin
      if (s2_rdy) begin
        s2_vld <= s1_vld;
      end
      if (s1_vld && s2_rdy) begin
        res_s  <= s1_q.s;
        res_e  <= nx_e;
        res_m  <= nx_m;
        nan    <= s1_q.nan;
        qnan   <= s1_q.qnan;
        inf    <= s1_q.inf;
        denorm <= s1_q.denorm;
        zero   <= s1_q.zero;
      end
    end
  end

endmodule

// File: tb/tb_fp_unpacker.sv
// Purpose : directed self-checking bench for fp_unpacker (EXP_W=8, MAN_W=23).
// Latency : expects results 2 cycles after the input transfer.
// Backpressure: exercises an out_ready stall window and a mid-flight reset.

module tb_fp_unpacker;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] op;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        res_s;
  logic [9:0]  res_e;
  logic [23:0] res_m;
  logic        nan, qnan, inf, denorm, zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_unpacker #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_s     (res_s),
    .res_e     (res_e),
    .res_m     (res_m),
    .nan       (nan),
    .qnan      (qnan),
    .inf       (inf),
    .denorm    (denorm),
    .zero      (zero)
  );

  logic [4:0]  flags;
  logic [39:0] out_vec;
  assign flags   = {nan, qnan, inf, denorm, zero};
  assign out_vec = {res_s, res_e, res_m, flags};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one operand and check latency plus every result field.
  task automatic send_one(input string tag, input logic [31:0] v, input logic es,
                          input logic [9:0] ee, input logic [23:0] em, input logic [4:0] ef);
    op       = v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_lat1_vld"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    chk({tag, "_s"},   64'(res_s),     64'(es));
    chk({tag, "_e"},   64'(res_e),     64'(ee));
    chk({tag, "_m"},   64'(res_m),     64'(em));
    chk({tag, "_flg"}, 64'(flags),     64'(ef));
  endtask

  // Stream operands: normal numbers with exponent 127+i and a varying fraction.
  function automatic logic [31:0] mk(input int i);
    logic [31:0] v;
    v = {i[0], 8'(127 + i), 23'(i * 37 + 5)};
    return v;
  endfunction

  function automatic logic [39:0] mk_exp(input int i);
    logic [39:0] v;
    v = {i[0], 10'(i), 1'b1, 23'(i * 37 + 5), 5'b00000};
    return v;
  endfunction

  initial begin
    int          sent;
    int          recv;
    logic        saw_low;
    logic        prev_stall;
    logic [39:0] snap;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = '0;

    // Reset state
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_outs",      64'(out_vec),   64'd0);

    // Release between edges; the first operand lands on the very next edge.
    #20;
    rst_n = 1'b1;
    send_one("one",     32'h3F800000, 1'b0, 10'd0,      24'h800000, 5'b00000);
    send_one("neg_pi",  32'hC0490FDB, 1'b1, 10'd1,      24'hC90FDB, 5'b00000);
    send_one("min_nrm", 32'h00800000, 1'b0, 10'(-126),  24'h800000, 5'b00000);
    send_one("max_nrm", 32'h7F7FFFFF, 1'b0, 10'd127,    24'hFFFFFF, 5'b00000);
    send_one("qnan",    32'h7FC00000, 1'b0, 10'd128,    24'h400000, 5'b11000);
    send_one("snan",    32'h7F800001, 1'b0, 10'd128,    24'h000001, 5'b10000);
    send_one("ninf",    32'hFF800000, 1'b1, 10'd128,    24'h000000, 5'b00100);
    send_one("nzero",   32'h80000000, 1'b1, 10'd0,      24'h000000, 5'b00001);
`ifdef FP_UNPACKER_DENORM_NORM_EN
    send_one("dn_min",  32'h00000001, 1'b0, 10'(-149),  24'h800000, 5'b00010);
    send_one("dn_top",  32'h80400000, 1'b1, 10'(-127),  24'h800000, 5'b00010);
`else
    send_one("dn_min",  32'h00000001, 1'b0, 10'd0,      24'h000000, 5'b00011);
    send_one("dn_top",  32'h80400000, 1'b1, 10'd0,      24'h000000, 5'b00011);
`endif

    // Eight back-to-back operands with out_ready low for cycles 3..6.
    sent       = 0;
    recv       = 0;
    saw_low    = 1'b0;
    prev_stall = 1'b0;
    snap       = '0;
    for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
      @(posedge clk); #1;
      in_valid  = (sent < 8);
      op        = mk(sent);
      out_ready = !(cyc >= 3 && cyc <= 6);
      @(negedge clk);
      if (prev_stall) chk("stall_hold", 64'(out_vec), 64'(snap));
      if (!in_ready) saw_low = 1'b1;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        chk($sformatf("strm_%0d", recv), 64'(out_vec), 64'(mk_exp(recv)));
        recv++;
      end
      prev_stall = out_valid && !out_ready;
      snap       = out_vec;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("strm_recv",     64'(recv),    64'd8);
    chk("strm_sent",     64'(sent),    64'd8);
    chk("strm_rdy_fell", 64'(saw_low), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("strm_no_dup", 64'(out_valid), 64'd0);

    // Fill both stages, then reset mid-cycle.
    out_ready = 1'b0;
    op        = mk(3);
    in_valid  = 1'b1;
    @(posedge clk); #1;
    op        = mk(5);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    chk("full_out_valid", 64'(out_valid), 64'd1);
    chk("full_in_ready",  64'(in_ready),  64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready",  64'(in_ready),  64'd1);
    chk("arst_outs",      64'(out_vec),   64'd0);
    out_ready = 1'b1;
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_idle_%0d", k), 64'(out_valid), 64'd0);
    end
    send_one("post_rst", 32'h40000000, 1'b0, 10'd1, 24'h800000, 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
